// File: rtl/debug_pkg.sv
// Shared definitions for the debug loader: FSM encoding, UART command bytes, widths.
package debug_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;
    localparam int CNT_W  = 16;

    localparam logic [BYTE_W-1:0] CMD_LOAD = 8'h4C;
    localparam logic [BYTE_W-1:0] CMD_RUN  = 8'h52;
    localparam logic [BYTE_W-1:0] CMD_STEP = 8'h53;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LD_CNT_HI,
        S_LD_CNT_LO,
        S_LD_BYTE,
        S_LD_WRITE,
        S_LD_DONE,
        S_RUN,
        S_STEP,
        S_TX_PC
    } state_e;

    // The core is held in reset for every loader state.
    function automatic logic is_load_state(state_e s);
        return s inside {S_LD_CNT_HI, S_LD_CNT_LO, S_LD_BYTE, S_LD_WRITE, S_LD_DONE};
    endfunction

endpackage

// File: rtl/pc_tx_serializer.sv
// Latches a 32-bit word and emits it as 4 bytes, MSB first, over a valid/ready port.
module pc_tx_serializer
    import debug_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [WORD_W-1:0] pc_i,
    input  logic              tx_ready_i,
    output logic              tx_valid_o,
    output logic [BYTE_W-1:0] tx_data_o,
    output logic              done_o
);

    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              active_q, active_d;
    logic              fire;

    assign fire = active_q & tx_ready_i;

    always_comb begin
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        if (load_i) begin
            shreg_d  = pc_i;
            cnt_d    = 2'd0;
            active_d = 1'b1;
        end else if (fire) begin
            // Shifting zeros in leaves tx_data at 0 once the word has drained.
            shreg_d = {shreg_q[WORD_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
            cnt_d   = cnt_q + 2'd1;
            if (cnt_q == 2'd3) active_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shreg_q  <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign tx_valid_o = active_q;
    assign tx_data_o  = shreg_q[WORD_W-1 -: BYTE_W];
    assign done_o     = fire && (cnt_q == 2'd3);

endmodule

// File: rtl/debug_loader_ctrl.sv
// Run-control / program loader: UART byte stream -> instruction memory, run/step gating, PC readback.
module debug_loader_ctrl
    import debug_pkg::*;
#(
    parameter int MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              tx_ready,
    output logic              tx_valid,
    output logic [BYTE_W-1:0] tx_data,
    input  logic              cpu_halt,
    input  logic [WORD_W-1:0] cpu_pc,
    output logic              cpu_reset,
    output logic              cpu_en,
    output logic              inst_mem_wr_en,
    output logic [WORD_W-1:0] inst_mem_addr,
    output logic [WORD_W-1:0] inst_mem_data,
    output logic              busy
);

    localparam logic [CNT_W:0] MAX_W = (CNT_W+1)'(MAX_WORDS);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic [1:0]         bcnt_q, bcnt_d;
    logic               cpu_reset_q;
    logic [CNT_W-1:0]   idx_nxt;
    logic               in_range;
    logic               tx_load;
    logic               tx_done;

    assign idx_nxt  = idx_q + 1'b1;
    assign in_range = {1'b0, idx_q} < MAX_W;
    assign tx_load  = (state_q != S_TX_PC) && (state_d == S_TX_PC);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (rx_valid) begin
                if      (rx_data == CMD_LOAD) state_d = S_LD_CNT_HI;
                else if (rx_data == CMD_RUN)  state_d = S_RUN;
                else if (rx_data == CMD_STEP) state_d = S_STEP;
            end
            S_LD_CNT_HI: if (rx_valid) state_d = S_LD_CNT_LO;
            S_LD_CNT_LO: if (rx_valid)
                state_d = ({cnt_q[CNT_W-1:BYTE_W], rx_data} == '0) ? S_LD_DONE : S_LD_BYTE;
            S_LD_BYTE:  if (rx_valid && bcnt_q == 2'd3) state_d = S_LD_WRITE;
            S_LD_WRITE: state_d = (idx_nxt == cnt_q) ? S_LD_DONE : S_LD_BYTE;
            S_LD_DONE:  state_d = S_IDLE;
            S_RUN:      if (cpu_halt) state_d = S_TX_PC;
            S_STEP:     state_d = S_TX_PC;
            S_TX_PC:    if (tx_done) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        idx_d  = idx_q;
        word_d = word_q;
        bcnt_d = bcnt_q;
        unique case (state_q)
            S_IDLE: if (rx_valid && rx_data == CMD_LOAD) begin
                idx_d  = '0;
                bcnt_d = '0;
                word_d = '0;
            end
            S_LD_CNT_HI: if (rx_valid) cnt_d[CNT_W-1:BYTE_W] = rx_data;
            S_LD_CNT_LO: if (rx_valid) cnt_d[BYTE_W-1:0] = rx_data;
            S_LD_BYTE: if (rx_valid) begin
                word_d = {word_q[WORD_W-BYTE_W-1:0], rx_data};
                bcnt_d = bcnt_q + 2'd1;
            end
            S_LD_WRITE: begin
                idx_d = idx_nxt;
                // A byte landing during the write cycle starts the next word.
                if (rx_valid && idx_nxt != cnt_q) begin
                    word_d = {word_q[WORD_W-BYTE_W-1:0], rx_data};
                    bcnt_d = bcnt_q + 2'd1;
                end
            end
            S_LD_DONE: idx_d = '0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            word_q      <= '0;
            bcnt_q      <= '0;
            cpu_reset_q <= 1'b1;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            word_q      <= word_d;
            bcnt_q      <= bcnt_d;
            cpu_reset_q <= is_load_state(state_d);
        end
    end

    always_comb begin
        cpu_reset      = cpu_reset_q;
        cpu_en         = (state_q == S_RUN || state_q == S_STEP) && !cpu_halt;
        inst_mem_wr_en = (state_q == S_LD_WRITE) && in_range;
        inst_mem_addr  = {{(WORD_W-CNT_W-2){1'b0}}, idx_q, 2'b00};
        inst_mem_data  = word_q;
        busy           = (state_q != S_IDLE);
    end

    pc_tx_serializer u_tx (
        .clk_i      (clk),
        .rst_i      (reset),
        .load_i     (tx_load),
        .pc_i       (cpu_pc),
        .tx_ready_i (tx_ready),
        .tx_valid_o (tx_valid),
        .tx_data_o  (tx_data),
        .done_o     (tx_done)
    );

endmodule

// File: tb/tb_debug_loader_ctrl.sv
// Directed bench for debug_loader_ctrl (MAX_WORDS=2 so the overflow path is reachable).
module tb_debug_loader_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_ready = 1'b1;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        cpu_halt = 1'b0;
    logic [31:0] cpu_pc = 32'h0;
    logic        cpu_reset, cpu_en, inst_mem_wr_en, busy;
    logic [31:0] inst_mem_addr, inst_mem_data;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [7:0]  tx_q[$];
    int          en_cnt = 0;

    always #5 clk = ~clk;

    debug_loader_ctrl #(.MAX_WORDS(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .tx_ready       (tx_ready),
        .tx_valid       (tx_valid),
        .tx_data        (tx_data),
        .cpu_halt       (cpu_halt),
        .cpu_pc         (cpu_pc),
        .cpu_reset      (cpu_reset),
        .cpu_en         (cpu_en),
        .inst_mem_wr_en (inst_mem_wr_en),
        .inst_mem_addr  (inst_mem_addr),
        .inst_mem_data  (inst_mem_data),
        .busy           (busy)
    );

    // Passive recorder: inputs change on negedge, so negedge+1 sees what the next posedge will see.
    initial forever begin
        @(negedge clk);
        #1;
        if (inst_mem_wr_en === 1'b1) begin
            wr_addr_q.push_back(inst_mem_addr);
            wr_data_q.push_back(inst_mem_data);
        end
        if (tx_valid === 1'b1 && tx_ready === 1'b1) tx_q.push_back(tx_data);
        if (cpu_en === 1'b1) en_cnt++;
    end

    task automatic clear_logs();
        wr_addr_q.delete();
        wr_data_q.delete();
        tx_q.delete();
        en_cnt = 0;
    endtask

    task automatic send_raw(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_raw(b);
        @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (busy !== 1'b0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s_idle_timeout busy=%b want 0", name, busy);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({tx_valid, tx_data, cpu_reset, cpu_en, inst_mem_wr_en, inst_mem_addr, inst_mem_data, busy}
            !== {1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_vals txv=%b txd=%h crst=%b en=%b we=%b a=%h d=%h busy=%b want 0 00 1 0 0 0 0 0",
                     tx_valid, tx_data, cpu_reset, cpu_en, inst_mem_wr_en, inst_mem_addr, inst_mem_data, busy);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (cpu_reset !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release_hold cpu_reset=%b want 1", cpu_reset);
        end
        @(negedge clk);
        n_cmp++;
        if (cpu_reset !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_first_clk cpu_reset=%b busy=%b want 0 0", cpu_reset, busy);
        end
        send_byte(8'h41);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL idle_ignore busy=%b want 0", busy);
        end
    endtask

    task automatic test_load();
        logic [7:0] bytes [8] = '{8'h3C, 8'h0B, 8'h00, 8'hF0, 8'h01, 8'h60, 8'h40, 8'h09};
        clear_logs();
        send_byte(8'h4C);
        n_cmp++;
        if (cpu_reset !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL load_enter cpu_reset=%b busy=%b want 1 1", cpu_reset, busy);
        end
        send_byte(8'h00);
        send_byte(8'h02);
        for (int i = 0; i < 8; i++) send_byte(bytes[i]);
        n_cmp++;
        if (cpu_reset !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL load_done_state cpu_reset=%b busy=%b want 1 1", cpu_reset, busy);
        end
        @(negedge clk);
        n_cmp++;
        if (cpu_reset !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL load_after_done cpu_reset=%b busy=%b want 0 0", cpu_reset, busy);
        end
        n_cmp++;
        if (wr_addr_q.size() != 2) begin
            n_err++;
            $display("FAIL load_wr_count got=%0d want 2", wr_addr_q.size());
        end else begin
            n_cmp++;
            if (wr_addr_q[0] !== 32'h0 || wr_data_q[0] !== 32'h3C0B00F0) begin
                n_err++;
                $display("FAIL load_wr0 addr=%h data=%h want 00000000 3c0b00f0", wr_addr_q[0], wr_data_q[0]);
            end
            n_cmp++;
            if (wr_addr_q[1] !== 32'h4 || wr_data_q[1] !== 32'h01604009) begin
                n_err++;
                $display("FAIL load_wr1 addr=%h data=%h want 00000004 01604009", wr_addr_q[1], wr_data_q[1]);
            end
        end
    endtask

    task automatic test_load_empty_step();
        logic [31:0] pc = 32'h12345678;
        logic [7:0]  got;
        clear_logs();
        send_byte(8'h4C);
        send_byte(8'h00);
        send_raw(8'h00);
        n_cmp++;
        if (busy !== 1'b1 || cpu_reset !== 1'b1) begin
            n_err++;
            $display("FAIL n0_ld_done busy=%b cpu_reset=%b want 1 1", busy, cpu_reset);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || cpu_reset !== 1'b0 || wr_addr_q.size() != 0) begin
            n_err++;
            $display("FAIL n0_idle busy=%b cpu_reset=%b writes=%0d want 0 0 0", busy, cpu_reset, wr_addr_q.size());
        end
        cpu_pc = pc;
        send_raw(8'h53);
        wait_idle("step");
        n_cmp++;
        if (en_cnt != 1) begin
            n_err++;
            $display("FAIL step_en_cycles got=%0d want 1", en_cnt);
        end
        n_cmp++;
        if (tx_q.size() != 4) begin
            n_err++;
            $display("FAIL step_tx_count got=%0d want 4", tx_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            got = (i < tx_q.size()) ? tx_q[i] : 8'hxx;
            n_cmp++;
            if (got !== pc[31-8*i -: 8]) begin
                n_err++;
                $display("FAIL step_tx_byte%0d got=%h want %h", i, got, pc[31-8*i -: 8]);
            end
        end
    endtask

    task automatic test_run();
        logic [31:0] pc = 32'h000000F0;
        logic [7:0]  got;
        clear_logs();
        cpu_pc = pc;
        send_raw(8'h52);
        repeat (7) @(negedge clk);
        cpu_halt = 1'b1;
        #1;
        n_cmp++;
        if (cpu_en !== 1'b0) begin
            n_err++;
            $display("FAIL run_halt_gate cpu_en=%b want 0", cpu_en);
        end
        wait_idle("run");
        n_cmp++;
        if (en_cnt != 7) begin
            n_err++;
            $display("FAIL run_en_cycles got=%0d want 7", en_cnt);
        end
        n_cmp++;
        if (tx_q.size() != 4) begin
            n_err++;
            $display("FAIL run_tx_count got=%0d want 4", tx_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            got = (i < tx_q.size()) ? tx_q[i] : 8'hxx;
            n_cmp++;
            if (got !== pc[31-8*i -: 8]) begin
                n_err++;
                $display("FAIL run_tx_byte%0d got=%h want %h", i, got, pc[31-8*i -: 8]);
            end
        end
        // Halt already high on entry: no enable cycle at all.
        clear_logs();
        cpu_pc = 32'hCAFE0010;
        send_raw(8'h52);
        wait_idle("run_halted");
        n_cmp++;
        if (en_cnt != 0 || tx_q.size() != 4) begin
            n_err++;
            $display("FAIL run_halted_entry en=%0d tx=%0d want 0 4", en_cnt, tx_q.size());
        end
        cpu_halt = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [31:0] pc = 32'hA1B2C3D4;
        clear_logs();
        cpu_pc   = pc;
        tx_ready = 1'b0;
        send_raw(8'h53);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 6; k++) begin
                n_cmp++;
                if (tx_valid !== 1'b1 || tx_data !== pc[31-8*i -: 8]) begin
                    n_err++;
                    $display("FAIL bp_hold_b%0d_c%0d valid=%b data=%h want 1 %h", i, k, tx_valid, tx_data, pc[31-8*i -: 8]);
                end
                if (k < 5) @(negedge clk);
            end
            tx_ready = 1'b1;
            @(negedge clk);
            tx_ready = 1'b0;
        end
        n_cmp++;
        if (busy !== 1'b0 || tx_valid !== 1'b0 || tx_q.size() != 4) begin
            n_err++;
            $display("FAIL bp_end busy=%b txv=%b sent=%0d want 0 0 4", busy, tx_valid, tx_q.size());
        end
        tx_ready = 1'b1;
    endtask

    task automatic test_overflow();
        clear_logs();
        send_byte(8'h4C);
        send_byte(8'h00);
        send_byte(8'h03);
        for (int i = 0; i < 12; i++) send_byte(8'(8'h10 + i));
        wait_idle("ovf");
        n_cmp++;
        if (wr_addr_q.size() != 2) begin
            n_err++;
            $display("FAIL ovf_wr_count got=%0d want 2", wr_addr_q.size());
        end else begin
            n_cmp++;
            if (wr_addr_q[0] !== 32'h0 || wr_data_q[0] !== 32'h10111213 ||
                wr_addr_q[1] !== 32'h4 || wr_data_q[1] !== 32'h14151617) begin
                n_err++;
                $display("FAIL ovf_writes a0=%h d0=%h a1=%h d1=%h want 0 10111213 4 14151617",
                         wr_addr_q[0], wr_data_q[0], wr_addr_q[1], wr_data_q[1]);
            end
        end
        n_cmp++;
        if (cpu_reset !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_cpu_reset got=%b want 0", cpu_reset);
        end
    endtask

    task automatic test_reset_mid_load();
        clear_logs();
        send_byte(8'h4C);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'hBB);
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({tx_valid, tx_data, cpu_reset, cpu_en, inst_mem_wr_en, inst_mem_addr, inst_mem_data, busy}
            !== {1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0}) begin
            n_err++;
            $display("FAIL midload_reset txv=%b txd=%h crst=%b en=%b we=%b a=%h d=%h busy=%b want 0 00 1 0 0 0 0 0",
                     tx_valid, tx_data, cpu_reset, cpu_en, inst_mem_wr_en, inst_mem_addr, inst_mem_data, busy);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        clear_logs();
        send_byte(8'h4C);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        wait_idle("reload");
        n_cmp++;
        if (wr_addr_q.size() != 1) begin
            n_err++;
            $display("FAIL reload_wr_count got=%0d want 1", wr_addr_q.size());
        end else begin
            n_cmp++;
            if (wr_addr_q[0] !== 32'h0 || wr_data_q[0] !== 32'h11223344) begin
                n_err++;
                $display("FAIL reload_wr0 addr=%h data=%h want 00000000 11223344", wr_addr_q[0], wr_data_q[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_load_empty_step();
        test_run();
        test_backpressure();
        test_overflow();
        test_reset_mid_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
